// File: rtl/drf_port_unit.sv
// drf_port_unit: parametrised memory-mapped I/O port block on the 8-bit DRF data bus.
//
// Each of CHANNELS channels (WIDTH bits) has a two-flop input synchroniser, a readable
// input register, a writable output latch, and per-bit rising-edge event capture with a
// mask. One interrupt line ORs all masked events.
//
// Register map per channel (reg = in_addr[1:0], channel = in_addr[ADDR_W-1:2]):
//   0 DATA_IN   (RO)  synchronised pins
//   1 DATA_OUT  (RW)  drives out_port
//   2 EDGE_MASK (RW)  1 enables rising-edge capture
//   3 EVENT     (R/W1C)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_addr          local register address
//   in_data          write data (bits above WIDTH ignored)
//   in_write_en      write strobe
//   in_read_en       read strobe
//   out_data         registered read data, zero-extended to 8 bits
//   out_data_valid   one cycle after each read strobe
//   in_port          external pins, channel c at [c*WIDTH +: WIDTH]
//   out_port         output latches, same packing
//   out_irq          OR of EVENT & EDGE_MASK over all channels
module drf_port_unit #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [7:0]                   in_data,
    input  logic                         in_write_en,
    input  logic                         in_read_en,
    output logic [7:0]                   out_data,
    output logic                         out_data_valid,
    input  logic [CHANNELS*WIDTH-1:0]    in_port,
    output logic [CHANNELS*WIDTH-1:0]    out_port,
    output logic                         out_irq
);

    // Channel-select width; a 2-bit address window still needs a 1-bit index.
    localparam int unsigned ChW = (ADDR_W > 2) ? ADDR_W - 2 : 1;

    typedef logic [CHANNELS-1:0][WIDTH-1:0] bank_t;

    bank_t sync1_q, sync2_q, prev_q;
    bank_t data_out_q, data_out_d;
    bank_t mask_q, mask_d;
    bank_t evt_q, evt_d, evt_clr, evt_set;

    logic [7:0]     out_data_q;
    logic           out_valid_q;
    logic [7:0]     rdata;
    logic [ChW-1:0] ch_idx;
    logic [1:0]     reg_sel;
    logic           ch_ok;
    logic           unused_data;

    // Upper data bits are legitimately ignored when WIDTH < 8.
    assign unused_data = ^in_data;

    generate
        if (ADDR_W > 2) begin : g_ch_idx
            assign ch_idx = in_addr[ADDR_W-1:2];
        end else begin : g_ch_zero
            assign ch_idx = '0;
        end
    endgenerate

    assign reg_sel = in_addr[1:0];
    // One extra bit so CHANNELS == 2^ChW compares correctly.
    assign ch_ok   = ({1'b0, ch_idx} < (ChW + 1)'(CHANNELS));

    // Rising edge on the synchronised pin, gated by the current mask.
    assign evt_set = sync2_q & ~prev_q & mask_q;

    always_comb begin
        rdata      = '0;
        data_out_d = data_out_q;
        mask_d     = mask_q;
        evt_clr    = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (ch_ok && (ch_idx == ChW'(c))) begin
                case (reg_sel)
                    2'd0: rdata = 8'(sync2_q[c]);
                    2'd1: rdata = 8'(data_out_q[c]);
                    2'd2: rdata = 8'(mask_q[c]);
                    2'd3: rdata = 8'(evt_q[c]);
                    default: rdata = '0;
                endcase
                if (in_write_en) begin
                    case (reg_sel)
                        2'd1:    data_out_d[c] = in_data[WIDTH-1:0];
                        2'd2:    mask_d[c]     = in_data[WIDTH-1:0];
                        2'd3:    evt_clr[c]    = in_data[WIDTH-1:0];
                        default: ;
                    endcase
                end
            end
        end
        // Set wins over a simultaneous write-1-to-clear so no event is lost.
        evt_d = (evt_q & ~evt_clr) | evt_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            data_out_q  <= '0;
            mask_q      <= '0;
            evt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sync1_q     <= in_port;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            data_out_q  <= data_out_d;
            mask_q      <= mask_d;
            evt_q       <= evt_d;
            out_valid_q <= in_read_en;
            // Read samples pre-write state, so a same-cycle write is not visible yet.
            if (in_read_en) begin
                out_data_q <= rdata;
            end
        end
    end

    assign out_data       = out_data_q;
    assign out_data_valid = out_valid_q;
    assign out_port       = data_out_q;
    assign out_irq        = |(evt_q & mask_q);

endmodule
